// File: rtl/move_entry.sv
// move_entry: synchronises and debounces nine cell buttons and turns each
// clean press into a one-cycle legal-move command or a one-cycle reject.
module move_entry #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [8:0] btn,
  input  logic [8:0] occ_cpu,
  input  logic       game_active,
  input  logic       clear,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       reject,
  output logic [8:0] user_occ
);
  typedef enum logic {IDLE, WAIT_REL} state_t;
  state_t state, state_nxt;
  logic [8:0] s1, btn_s, prev, stable;
  logic [CNT_W-1:0] cnt;
  logic eval, acc;
  logic [3:0] idx;
  // stable is loaded on the same edge the counter becomes DB_CYCLES-1
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      s1     <= '0;
      btn_s  <= '0;
      prev   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      s1    <= btn;
      btn_s <= s1;
      prev  <= btn_s;
      cnt   <= (btn_s != prev) ? '0 : (&cnt) ? cnt : cnt + 1'b1;
      if (btn_s == prev && cnt == CNT_W'(DB_CYCLES - 2)) stable <= btn_s;
    end
  always_comb begin
    eval      = state == IDLE && stable != '0 && !clear;
    acc       = eval && (stable & (stable - 9'd1)) == '0 && game_active &&
                (stable & (user_occ | occ_cpu)) == '0;
    state_nxt = (stable != '0) ? WAIT_REL : IDLE;
    idx       = '0;
    for (int i = 0; i < 9; i++) if (stable[i]) idx = 4'(i);
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      cmd       <= '0;
      cmd_valid <= 1'b0;
      reject    <= 1'b0;
      user_occ  <= '0;
    end else begin
      cmd_valid <= acc;
      reject    <= eval && !acc;
      if (acc) cmd <= idx;
      user_occ  <= clear ? '0 : acc ? (user_occ | stable) : user_occ;
    end
endmodule

// File: tb/tb_move_entry.sv
// tb_move_entry: directed presses with a queue of expected pulses checked by
// an independent monitor (kind, cmd, user_occ and arrival cycle).
module tb_move_entry;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [8:0] btn = '0;
  logic [8:0] occ_cpu = '0;
  logic       game_active = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       reject;
  logic [8:0] user_occ;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    bit         v;
    logic [3:0] cmd;
    logic [8:0] occ;
    int         cyc;
  } exp_t;
  exp_t q[$];

  move_entry #(.DB_CYCLES(4), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .btn(btn), .occ_cpu(occ_cpu),
    .game_active(game_active), .clear(clear), .cmd(cmd),
    .cmd_valid(cmd_valid), .reject(reject), .user_occ(user_occ)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Drive a new button vector and, if a pulse is due, queue it 7 cycles out
  task automatic press(input logic [8:0] v, input bit pulse, input bit ok,
                       input logic [3:0] c, input logic [8:0] o);
    exp_t e;
    @(negedge CLK);
    btn = v;
    if (pulse) begin
      e.v = ok; e.cmd = c; e.occ = o; e.cyc = cyc + 7;
      q.push_back(e);
    end
  endtask

  always @(negedge CLK) begin
    if (RST && (cmd_valid || reject)) begin
      exp_t e;
      chk("valid_and_reject_exclusive", {31'd0, cmd_valid & reject}, 32'd0);
      if (q.size() == 0) chk("unexpected_pulse", {31'd0, cmd_valid}, {31'd0, reject});
      else begin
        e = q.pop_front();
        chk("pulse_kind_valid", {31'd0, cmd_valid}, {31'd0, e.v});
        chk("pulse_cmd", {28'd0, cmd}, {28'd0, e.cmd});
        chk("pulse_user_occ", {23'd0, user_occ}, {23'd0, e.occ});
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    wait_cyc(3);
    chk("reset_cmd", {28'd0, cmd}, 32'd0);
    chk("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("reset_reject", {31'd0, reject}, 32'd0);
    chk("reset_user_occ", {23'd0, user_occ}, 32'd0);
    RST = 1'b1;
    wait_cyc(10);
    // clean press of cell 4, held long
    press(9'h010, 1, 1, 4'd4, 9'h010);
    wait_cyc(50);
    chk("held_user_occ", {23'd0, user_occ}, 32'h010);
    press(9'h000, 0, 0, 4'd0, 9'h0);
    wait_cyc(15);
    // cell 4 taken by user, cell 7 by cpu
    press(9'h010, 1, 0, 4'd4, 9'h010);
    wait_cyc(15);
    press(9'h000, 0, 0, 4'd0, 9'h0);
    wait_cyc(15);
    occ_cpu = 9'h080;
    press(9'h080, 1, 0, 4'd4, 9'h010);
    wait_cyc(15);
    press(9'h000, 0, 0, 4'd0, 9'h0);
    wait_cyc(15);
    occ_cpu = 9'h000;
    // bouncing cell 2
    for (int i = 0; i < 10; i++) press((i % 2 == 0) ? 9'h004 : 9'h000, 0, 0, 4'd0, 9'h0);
    press(9'h004, 1, 1, 4'd2, 9'h014);
    wait_cyc(15);
    press(9'h000, 0, 0, 4'd0, 9'h0);
    wait_cyc(15);
    // two buttons, partial release, full release, single press
    press(9'h003, 1, 0, 4'd2, 9'h014);
    wait_cyc(15);
    press(9'h001, 0, 0, 4'd0, 9'h0);
    wait_cyc(15);
    press(9'h000, 0, 0, 4'd0, 9'h0);
    wait_cyc(15);
    press(9'h001, 1, 1, 4'd0, 9'h015);
    wait_cyc(15);
    press(9'h000, 0, 0, 4'd0, 9'h0);
    wait_cyc(15);
    // game over
    game_active = 1'b0;
    press(9'h100, 1, 0, 4'd0, 9'h015);
    wait_cyc(15);
    press(9'h000, 0, 0, 4'd0, 9'h0);
    wait_cyc(15);
    game_active = 1'b1;
    // clear while cell 1 held
    press(9'h002, 1, 1, 4'd1, 9'h017);
    wait_cyc(15);
    clear = 1'b1;
    wait_cyc(1);
    clear = 1'b0;
    chk("clear_user_occ", {23'd0, user_occ}, 32'd0);
    wait_cyc(15);
    press(9'h000, 0, 0, 4'd0, 9'h0);
    wait_cyc(15);
    press(9'h002, 1, 1, 4'd1, 9'h002);
    wait_cyc(15);
    press(9'h000, 0, 0, 4'd0, 9'h0);
    wait_cyc(15);
    // async reset mid-debounce of cell 5
    press(9'h020, 0, 0, 4'd0, 9'h0);
    wait_cyc(3);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_cmd", {28'd0, cmd}, 32'd0);
    chk("async_rst_user_occ", {23'd0, user_occ}, 32'd0);
    chk("async_rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    wait_cyc(2);
    begin
      exp_t e;
      e.v = 1; e.cmd = 4'd5; e.occ = 9'h020; e.cyc = cyc + 7;
      q.push_back(e);
      RST = 1'b1;
    end
    wait_cyc(20);
    chk("all_expected_pulses_seen", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
